// File: rtl/operand_hazard_unit.sv
// Decode-stage operand resolver: scoreboard busy check, youngest-first forwarding,
// register-file fallback, plus a per-register latency scoreboard and a stall counter.
module operand_hazard_unit #(
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_LAT = 7,
  parameter int unsigned LAT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD-1:0]       rd_en_i,
  input  logic [5*NUM_RD-1:0]     rd_addr_i,
  input  logic [DW*NUM_RD-1:0]    rf_data_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [NUM_FWD-1:0]      fwd_ready_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [DW*NUM_FWD-1:0]   fwd_wdata_i,
  input  logic                    issue_i,
  input  logic [4:0]              issue_waddr_i,
  input  logic [LAT_W-1:0]        issue_lat_i,
  output logic [DW*NUM_RD-1:0]    op_data_o,
  output logic                    stall_o,
  output logic [31:0]             busy_o,
  output logic [31:0]             stall_cnt_o
);

  logic [LAT_W-1:0]  r_cnt [32];
  logic [31:0]       r_stall_cnt;

  logic [NUM_RD-1:0] w_port_stall;
  logic [NUM_RD-1:0] w_hit;
  logic [4:0]        w_addr [NUM_RD];
  logic              w_waw;
  logic              w_accept;
  logic [LAT_W-1:0]  w_lat;

  // Scoreboard view: a register is busy while its countdown is nonzero.
  always_comb begin
    busy_o = '0;
    for (int r = 1; r < 32; r++) begin
      busy_o[r] = (r_cnt[r] != '0);
    end
  end

  // Per-port resolution; the first matching stage (youngest) decides, older ones are ignored.
  always_comb begin
    op_data_o    = '0;
    w_port_stall = '0;
    w_hit        = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_addr[k] = rd_addr_i[5*k +: 5];
      if (!rst && rd_en_i[k] && (w_addr[k] != 5'd0)) begin
        if (busy_o[w_addr[k]]) begin
          w_port_stall[k] = 1'b1;
        end else begin
          for (int j = 0; j < NUM_FWD; j++) begin
            if (!w_hit[k] && fwd_we_i[j] && (fwd_waddr_i[5*j +: 5] == w_addr[k])) begin
              w_hit[k] = 1'b1;
              if (fwd_ready_i[j]) begin
                op_data_o[DW*k +: DW] = fwd_wdata_i[DW*j +: DW];
              end else begin
                w_port_stall[k] = 1'b1;
              end
            end
          end
          if (!w_hit[k]) begin
            op_data_o[DW*k +: DW] = rf_data_i[DW*k +: DW];
          end
        end
      end
    end
  end

  // Global stall, write-after-write check and issue acceptance.
  always_comb begin
    w_waw    = !rst && issue_i && (issue_waddr_i != 5'd0) && busy_o[issue_waddr_i];
    stall_o  = !rst && ((|w_port_stall) || w_waw);
    w_accept = !rst && issue_i && !stall_o && (issue_waddr_i != 5'd0);
    if (issue_lat_i == '0) begin
      w_lat = LAT_W'(1);
    end else if (issue_lat_i > LAT_W'(MAX_LAT)) begin
      w_lat = LAT_W'(MAX_LAT);
    end else begin
      w_lat = issue_lat_i;
    end
  end

  // Countdown per register and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        r_cnt[r] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (w_accept && (issue_waddr_i == 5'(r))) begin
          r_cnt[r] <= w_lat;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - LAT_W'(1);
        end
      end
      if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_operand_hazard_unit.sv
// Directed bench for operand_hazard_unit: a vector table for single-cycle resolution
// and hand-written sequences for scoreboard timing, clamping, WAW and reset.
module tb_operand_hazard_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [1:0]  fwd_we;
  logic [1:0]  fwd_ready;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        issue;
  logic [4:0]  issue_waddr;
  logic [2:0]  issue_lat;
  logic [63:0] op_data;
  logic        stall;
  logic [31:0] busy;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  operand_hazard_unit #(
    .NUM_RD(2), .NUM_FWD(2), .DW(32), .MAX_LAT(5), .LAT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rf_data_i(rf_data),
    .fwd_we_i(fwd_we), .fwd_ready_i(fwd_ready), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
    .issue_i(issue), .issue_waddr_i(issue_waddr), .issue_lat_i(issue_lat),
    .op_data_o(op_data), .stall_o(stall), .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  en;
    logic [4:0]  a0, a1;
    logic [31:0] rf0, rf1;
    logic [1:0]  we, rdy;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [31:0] e0, e1;
    logic        es;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; rf_data = '0;
    fwd_we = '0; fwd_ready = '0; fwd_waddr = '0; fwd_wdata = '0;
    issue = 1'b0; issue_waddr = '0; issue_lat = '0;
  endtask

  // Drive at the falling edge, settle, then compare before the next rising edge.
  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic settle(input logic exp_stall);
    #2;
    if (exp_stall) exp_cnt++;
  endtask

  task automatic read0(input logic [4:0] a, input logic [31:0] rf);
    rd_en[0] = 1'b1; rd_addr[4:0] = a; rf_data[31:0] = rf;
  endtask

  task automatic do_issue(input logic [4:0] a, input logic [2:0] lat);
    issue = 1'b1; issue_waddr = a; issue_lat = lat;
  endtask

  initial begin
    vt[0] = '{"fwd_prio",   2'b01, 5'd5,  5'd0,  32'h5555, 32'h0,  2'b11, 2'b11, 5'd5, 5'd5,  32'hAAAA0000, 32'h1111, 32'hAAAA0000, 32'h0, 1'b0};
    vt[1] = '{"fwd_older",  2'b11, 5'd6,  5'd3,  32'h66,   32'h33, 2'b11, 2'b11, 5'd4, 5'd6,  32'h44,       32'h1616, 32'h1616,     32'h33, 1'b0};
    vt[2] = '{"load_use",   2'b10, 5'd0,  5'd7,  32'h0,    32'h77, 2'b11, 2'b10, 5'd7, 5'd7,  32'hDEAD,     32'h9999, 32'h0,        32'h0, 1'b1};
    vt[3] = '{"load_done",  2'b10, 5'd0,  5'd7,  32'h0,    32'h77, 2'b11, 2'b11, 5'd7, 5'd7,  32'h42,       32'h9999, 32'h0,        32'h42, 1'b0};
    vt[4] = '{"read_r0",    2'b11, 5'd0,  5'd0,  32'h123,  32'h456,2'b01, 2'b00, 5'd0, 5'd0,  32'hBEEF,     32'h0,    32'h0,        32'h0, 1'b0};
    vt[5] = '{"we_off",     2'b11, 5'd8,  5'd9,  32'h88,   32'h99, 2'b00, 2'b11, 5'd8, 5'd9,  32'h1,        32'h2,    32'h88,       32'h99, 1'b0};
    vt[6] = '{"disabled",   2'b00, 5'd7,  5'd7,  32'h70,   32'h71, 2'b01, 2'b00, 5'd7, 5'd0,  32'h0,        32'h0,    32'h0,        32'h0, 1'b0};
    vt[7] = '{"port1_only", 2'b11, 5'd10, 5'd11, 32'hA0,   32'hB0, 2'b10, 2'b00, 5'd0, 5'd11, 32'h0,        32'h5,    32'hA0,       32'h0, 1'b1};

    idle();
    rst = 1'b1;
    // Reset: outputs quiet and state cleared, even with an enabled read present.
    next_cycle(); rst = 1'b1; read0(5'd5, 32'h1234); do_issue(5'd2, 3'd3);
    settle(1'b0);
    next_cycle(); rst = 1'b1; read0(5'd5, 32'h1234);
    settle(1'b0);
    chk("rst_op_data", op_data[31:0], 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);

    // Table-driven combinational resolution; scoreboard empty.
    for (int i = 0; i < 8; i++) begin
      next_cycle(); rst = 1'b0;
      rd_en = vt[i].en; rd_addr = {vt[i].a1, vt[i].a0}; rf_data = {vt[i].rf1, vt[i].rf0};
      fwd_we = vt[i].we; fwd_ready = vt[i].rdy; fwd_waddr = {vt[i].wa1, vt[i].wa0};
      fwd_wdata = {vt[i].wd1, vt[i].wd0};
      settle(vt[i].es);
      chk({vt[i].name, "_op0"}, op_data[31:0], vt[i].e0);
      chk({vt[i].name, "_op1"}, op_data[63:32], vt[i].e1);
      chk({vt[i].name, "_stall"}, {31'd0, stall}, {31'd0, vt[i].es});
    end
    next_cycle(); rst = 1'b0; settle(1'b0);
    chk("table_stall_cnt", stall_cnt, 32'(exp_cnt));

    // Scoreboard: r9 lat 3 -> busy and stalling for three cycles, then rf data.
    next_cycle(); do_issue(5'd9, 3'd3); settle(1'b0);
    chk("sb_issue_stall", {31'd0, stall}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); read0(5'd9, 32'h9090); settle(1'b1);
      chk("sb_busy", busy, 32'h200);
      chk("sb_stall", {31'd0, stall}, 32'h1);
      chk("sb_op0", op_data[31:0], 32'h0);
    end
    next_cycle(); read0(5'd9, 32'h9090); settle(1'b0);
    chk("sb_clear_busy", busy, 32'h0);
    chk("sb_clear_stall", {31'd0, stall}, 32'h0);
    chk("sb_clear_op0", op_data[31:0], 32'h9090);
    chk("sb_stall_cnt", stall_cnt, 32'(exp_cnt));

    // Clamp low: lat 0 behaves as 1.
    next_cycle(); do_issue(5'd3, 3'd0); settle(1'b0);
    next_cycle(); settle(1'b0);
    chk("lat0_busy", busy, 32'h8);
    next_cycle(); settle(1'b0);
    chk("lat0_clear", busy, 32'h0);

    // Clamp high (7 -> 5), rejected WAW reissue, unrelated issue during countdown.
    next_cycle(); do_issue(5'd4, 3'd7); settle(1'b0);
    for (int c = 1; c <= 6; c++) begin
      logic [31:0] eb;
      logic        es;
      next_cycle();
      es = 1'b0;
      if (c == 1) begin do_issue(5'd4, 3'd1); es = 1'b1; end
      if (c == 2) do_issue(5'd6, 3'd2);
      settle(es);
      eb = '0;
      if (c <= 5) eb[4] = 1'b1;
      if (c == 3 || c == 4) eb[6] = 1'b1;
      chk($sformatf("clamp_busy_c%0d", c), busy, eb);
      chk($sformatf("clamp_stall_c%0d", c), {31'd0, stall}, {31'd0, es});
    end

    // Issue while a read stalls on a load-use hazard is not accepted.
    next_cycle(); read0(5'd7, 32'h0); fwd_we = 2'b01; fwd_waddr[4:0] = 5'd7;
    do_issue(5'd13, 3'd2); settle(1'b1);
    chk("blocked_issue_stall", {31'd0, stall}, 32'h1);
    next_cycle(); settle(1'b0);
    chk("blocked_issue_busy", busy, 32'h0);

    // Issue to r0 is ignored and never stalls.
    next_cycle(); do_issue(5'd0, 3'd3); settle(1'b0);
    chk("r0_issue_stall", {31'd0, stall}, 32'h0);
    next_cycle(); settle(1'b0);
    chk("r0_issue_busy", busy, 32'h0);

    // Disabled port on a busy register: data 0, no stall.
    next_cycle(); do_issue(5'd20, 3'd2); settle(1'b0);
    next_cycle(); rd_addr = {5'd20, 5'd20}; rf_data = {32'h2020, 32'h2020}; settle(1'b0);
    chk("dis_busy", busy, 32'h0010_0000);
    chk("dis_stall", {31'd0, stall}, 32'h0);
    chk("dis_op", op_data[31:0], 32'h0);
    chk("pre_rst_stall_cnt", stall_cnt, 32'(exp_cnt));

    // Reset mid-countdown clears scoreboard and stall counter.
    next_cycle(); do_issue(5'd12, 3'd5); settle(1'b0);
    next_cycle(); read0(5'd12, 32'h0); settle(1'b1);
    next_cycle(); rst = 1'b1; read0(5'd12, 32'hC0C0); settle(1'b0);
    chk("midrst_busy_before", busy, 32'h1000);
    chk("midrst_stall", {31'd0, stall}, 32'h0);
    chk("midrst_op", op_data[31:0], 32'h0);
    exp_cnt = 0;
    next_cycle(); rst = 1'b0; read0(5'd12, 32'hC0C0); settle(1'b0);
    chk("postrst_busy", busy, 32'h0);
    chk("postrst_stall_cnt", stall_cnt, 32'h0);
    chk("postrst_stall", {31'd0, stall}, 32'h0);
    chk("postrst_op", op_data[31:0], 32'hC0C0);

    next_cycle(); settle(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_hazard_unit.md
# operand_hazard_unit

Parametrised operand resolver and hazard scoreboard for the decode stage. It serves NUM_RD register read ports and resolves each operand by priority: scoreboard busy, then forwarding from NUM_FWD pipeline stages, then the register file. It raises a single stall whenever any enabled operand is not yet available. A per-register latency scoreboard tracks in-flight long-latency writes (multi-cycle MUL, slow loads), and a saturating stall counter is provided for performance monitoring.

## Interface
- NUM_RD, 2, number of operand read ports
- NUM_FWD, 2, number of forwarding source stages; index 0 = youngest (EX), index NUM_FWD-1 = oldest
- DW, 32, data width
- MAX_LAT, 7, maximum scoreboard latency in cycles
- LAT_W, 3, width of latency field, equal to clog2(MAX_LAT+1)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  5*NUM_RD  per-port register address; port k at bits [5k+4:5k]
- rf_data_i  in  DW*NUM_RD  register-file read data per port
- fwd_we_i  in  NUM_FWD  stage write enable
- fwd_ready_i  in  NUM_FWD  stage result valid this cycle; 0 means load/mul result not yet produced
- fwd_waddr_i  in  5*NUM_FWD  stage destination register
- fwd_wdata_i  in  DW*NUM_FWD  stage result data
- issue_i  in  1  instruction in decode starts a long-latency write
- issue_waddr_i  in  5  destination of that write
- issue_lat_i  in  LAT_W  cycles until the result is architecturally visible
- op_data_o  out  DW*NUM_RD  resolved operand per port
- stall_o  out  1  hold decode and fetch this cycle
- busy_o  out  32  scoreboard busy vector; bit 0 always 0
- stall_cnt_o  out  32  stall-cycle counter

## Operation
- Per-port resolution is combinational, in priority order:
  - rd_en=0 → data 0, no stall contribution.
  - addr=0 → data forced 0, never stalls, never forwarded.
  - busy_o[addr]=1 → stall, data 0.
  - Otherwise, find the lowest-index stage j with fwd_we[j]=1 and fwd_waddr[j]=addr. If fwd_ready[j]=1, data = fwd_wdata[j]. If fwd_ready[j]=0, stall and data 0. Older matching stages are never consulted.
  - No stage matches → data = rf_data.
- The issue WAW check raises stall when issue_i=1, issue_waddr≠0 and busy_o[issue_waddr]=1.
- stall_o = OR of all port stalls and the WAW stall.
- Issue is accepted when issue_i=1, stall_o=0 and issue_waddr≠0. An issue to r0 is ignored and never stalls.
- Scoreboard holds one LAT_W-bit down-counter per register 1..31; busy_o[r] = (cnt[r]≠0).
  - Accepted issue loads cnt[waddr] with L = clamp(issue_lat_i, 1, MAX_LAT). A value of 0 is treated as 1; values above MAX_LAT saturate to MAX_LAT.
  - Every other nonzero counter decrements by 1 each cycle; zero counters hold.
  - An accepted issue never targets a busy register, so load and decrement never collide.
- The scoreboard does not forward. The long-latency unit delivers its result through a forwarding port or the register file no later than the cycle busy clears.
- stall_cnt_o increments by 1 every cycle stall_o=1 and saturates at 32'hFFFF_FFFF.

## Timing
- op_data_o and stall_o are combinational from inputs and the scoreboard state; zero-cycle latency.
- Issue accepted at edge t (sampled in cycle t) → busy_o[r]=1 in cycles t+1 .. t+L, and 0 from cycle t+L+1.
  - A read of r stalls in cycles t+1..t+L and resolves normally in cycle t+L+1.
- Stall-counter update is registered: a stall in cycle t is visible in stall_cnt_o at cycle t+1.
- Reset, applied at any edge including mid-countdown:
  - all counters → 0, busy_o → 0, stall_cnt_o → 0 at the next edge.
  - while rst=1: op_data_o = 0, stall_o = 0, and issues are ignored.
- Simultaneous events:
  - issue_i in the same cycle a read of issue_waddr stalls for another reason → issue not accepted; the decoder re-presents it.
  - The counter of an unrelated register keeps decrementing during stalls.

## Test plan
- Forward priority: fwd0 {we=1, addr=5, ready=1, data=0xAAAA0000}, fwd1 {we=1, addr=5, data=0x1111}, port0 reads r5 → op_data0=0xAAAA0000, stall_o=0.
- Load-use: fwd0 {we=1, addr=7, ready=0}, fwd1 {addr=7, ready=1}, port1 reads r7 → stall_o=1. Next cycle fwd0 {ready=1, data=0x42} → op_data1=0x42, stall_o=0.
- Scoreboard: issue r9 with lat=3 at cycle 10 → busy_o[9]=1 in cycles 11–13. A read of r9 stalls in cycles 11–13 and returns rf_data in cycle 14. stall_cnt_o increases by 3.
- Latency clamp and WAW: issue lat=0 → busy for 1 cycle; issue lat=7 with MAX_LAT=5 → busy for 5 cycles. A second issue to a busy register → stall_o=1, issue not accepted, original count unchanged.
- r0 and disabled ports: read r0 with fwd0 {addr=0, ready=0} → op_data=0, no stall. rd_en=0 with busy address → data 0, no stall. Issue to r0 → busy_o=0.
- Reset mid-operation: assert rst while cnt[12]=4 and stall_cnt_o=20 → next cycle busy_o=0 and stall_cnt_o=0. Reads of r12 after rst deasserts resolve without stall.
